// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational ROM and registers
// the fetched word into IF/ID. Handles stall, redirect flush and halt-on-opcode.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 9,
  parameter logic [PC_W-1:0] RESET_PC = 16'd1,
  parameter logic [4:0]      HALT_OP  = 5'b11010
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                vld_q, vld_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_W-1:0]     ipc_q, ipc_d;
  logic                is_halt;

  assign is_halt = (rom_inst[INST_W-1 -: 5] == HALT_OP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: redirect beats stall beats normal fetch
  always_comb begin
    state_d = state_q;
    if (redirect_valid)                          state_d = RUN;
    else if (!stall && state_q == RUN && is_halt) state_d = HALTED;
  end

  // Outputs
  always_comb begin
    halted = (state_q == HALTED);
  end

  // Datapath next-state
  always_comb begin
    pc_d   = pc_q;
    vld_d  = vld_q;
    inst_d = inst_q;
    ipc_d  = ipc_q;
    if (redirect_valid) begin
      pc_d  = redirect_pc;
      vld_d = 1'b0;
    end else if (!stall) begin
      if (state_q == RUN) begin
        inst_d = rom_inst;
        ipc_d  = pc_q;
        vld_d  = 1'b1;
        if (!is_halt) pc_d = pc_q + 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      vld_q  <= 1'b0;
      inst_q <= '0;
      ipc_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      vld_q  <= vld_d;
      inst_q <= inst_d;
      ipc_q  <= ipc_d;
    end
  end

  assign pc       = pc_q;
  assign if_valid = vld_q;
  assign if_inst  = inst_q;
  assign if_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural ROM and an expected-result queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [8:0]  rom_inst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [8:0]  if_inst;
  logic [15:0] if_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic        vld;
    logic [15:0] ipc;
    logic [8:0]  inst;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .rom_inst(rom_inst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_f(input logic [15:0] a);
    case (a)
      16'd1:   return 9'h060;
      16'd2:   return 9'h090;
      16'd3:   return 9'h190;
      16'd43:  return 9'h1A0;
      default: return {5'h01, a[3:0]};
    endcase
  endfunction

  always_comb rom_inst = rom_f(pc);

  function automatic exp_t E(input logic [15:0] p, input logic v, input logic [15:0] ip,
                             input logic [8:0] in, input logic h);
    exp_t e;
    e.pc = p; e.vld = v; e.ipc = ip; e.inst = in; e.hlt = h;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input exp_t e);
    chk("pc",       pc,                e.pc);
    chk("if_valid", {15'd0, if_valid}, {15'd0, e.vld});
    chk("if_pc",    if_pc,             e.ipc);
    chk("if_inst",  {7'd0, if_inst},   {7'd0, e.inst});
    chk("halted",   {15'd0, halted},   {15'd0, e.hlt});
  endtask

  // Push expectation for the coming edge, clock once, pop and compare.
  task automatic step(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_now(got);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    check_now(E(16'd1, 0, 16'd0, 9'h000, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Free run from reset
    step(E(16'd2, 1, 16'd1, 9'h060, 0));
    step(E(16'd3, 1, 16'd2, 9'h090, 0));

    // Stall three cycles, then release
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(E(16'd3, 1, 16'd2, 9'h090, 0));
    stall = 1'b0;
    step(E(16'd4, 1, 16'd3, 9'h190, 0));
    for (int a = 4; a < 15; a++) step(E(16'(a + 1), 1, 16'(a), rom_f(16'(a)), 0));

    // Redirect together with stall: flush wins
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd26;
    step(E(16'd26, 0, 16'd14, rom_f(16'd14), 0));
    stall = 1'b0; redirect_valid = 1'b0;
    step(E(16'd27, 1, 16'd26, rom_f(16'd26), 0));
    for (int a = 27; a < 43; a++) step(E(16'(a + 1), 1, 16'(a), rom_f(16'(a)), 0));

    // Halt at 43: delivered once, then fetch stops
    step(E(16'd43, 1, 16'd43, 9'h1A0, 1));
    for (int i = 0; i < 10; i++) step(E(16'd43, 0, 16'd43, 9'h1A0, 1));
    stall = 1'b1;
    step(E(16'd43, 0, 16'd43, 9'h1A0, 1));
    stall = 1'b0;

    // Redirect out of halt
    redirect_valid = 1'b1; redirect_pc = 16'd5;
    step(E(16'd5, 0, 16'd43, 9'h1A0, 0));
    redirect_valid = 1'b0;
    step(E(16'd6, 1, 16'd5, rom_f(16'd5), 0));
    step(E(16'd7, 1, 16'd6, rom_f(16'd6), 0));

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    step(E(16'hFFFF, 0, 16'd6, rom_f(16'd6), 0));
    redirect_valid = 1'b0;
    step(E(16'h0000, 1, 16'hFFFF, rom_f(16'hFFFF), 0));
    step(E(16'h0001, 1, 16'h0000, rom_f(16'h0000), 0));

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_now(E(16'd1, 0, 16'd0, 9'h000, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
